// File: rtl/modacc.sv
// modacc: streaming modular accumulator.
// Sums the beats of each frame modulo q = {qH, zeros, 1'b1} and presents the
// frame sum together with the beat count once the last beat has been taken.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   qH           modulus high part, latched on the first beat of each frame
//   in_valid     beat offered by the producer
//   in_ready     block accepts a beat this cycle (low while a result is pending)
//   in_data      residue to accumulate (assumed < q)
//   in_last      marks the final beat of a frame
//   out_valid    frame result available
//   out_ready    consumer takes the result
//   out_data     frame sum mod q
//   out_count    beats in the frame, saturating at 2^CW-1
module modacc #(
    parameter int unsigned LOGQ  = 64,
    parameter int unsigned LOGQH = 47,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LOGQH-1:0] qH,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGQ-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  out_data,
    output logic [CW-1:0]    out_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [LOGQ-1:0] acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [LOGQ-1:0] q_reg_q, q_reg_d;

    logic [LOGQ-1:0] q_new;
    logic [LOGQ:0]   sum_s;
    logic [LOGQ:0]   sum_t;
    logic [LOGQ-1:0] mod_sum;
    logic            beat;
    logic            result;

    assign q_new = {qH, {(LOGQ - LOGQH - 1){1'b0}}, 1'b1};

    // One conditional subtraction: both operands are < q, so S < 2q.
    // A borrow out of T means S < q and S is already reduced.
    assign sum_s   = {1'b0, acc_q} + {1'b0, in_data};
    assign sum_t   = sum_s - {1'b0, q_reg_q};
    assign mod_sum = sum_t[LOGQ] ? sum_s[LOGQ-1:0] : sum_t[LOGQ-1:0];

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign out_count = count_q;

    assign beat   = in_valid && in_ready;
    assign result = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        q_reg_d = q_reg_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    q_reg_d = q_new;
                    acc_d   = in_data;
                    count_d = CW'(1);
                    state_d = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_d   = mod_sum;
                    count_d = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);
                    state_d = in_last ? DONE : ACC;
                end
            end
            DONE: begin
                if (result) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            q_reg_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            q_reg_q <= q_reg_d;
        end
    end

endmodule

// File: doc/modacc.md
MODACC -- requirements
Module: modacc

Interface
REQ-001 Parameter LOGQ, default 64, operand and modulus width in bits.
REQ-002 Parameter LOGQH, default 47, width of the modulus high part qH.
REQ-003 Parameter CW, default 16, width of the beat counter.
REQ-004 Modulus q SHALL equal {qH, (LOGQ-LOGQH-1) zero bits, 1'b1}, i.e. q = qH*2^(LOGQ-LOGQH) + 1.
REQ-005 Port list, in this order:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- qH  in  LOGQH  modulus high part; sampled on the first beat of each frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  LOGQ  residue to accumulate; producer guarantees in_data < q.
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  LOGQ  frame sum mod q.
- out_count  out  CW  number of beats in the frame, saturating.

Function
REQ-006 States IDLE, ACC, DONE; a beat transfers when in_valid && in_ready, a result when out_valid && out_ready.
REQ-007 in_ready SHALL be 1 in IDLE and ACC, 0 in DONE; out_valid SHALL be 1 only in DONE.
REQ-008 IDLE, beat transfers: q_reg <= q from current qH; acc <= in_data; count <= 1; next state DONE if in_last, else ACC.
REQ-009 ACC, beat transfers: acc <= modular sum of acc and in_data, computed with q_reg; count <= count+1 saturating at 2^CW-1; next state DONE if in_last, else stay in ACC.
REQ-010 Modular sum: S = acc + in_data at LOGQ+1 bits; T = S - q at LOGQ+1 bits; result = T[LOGQ-1:0] if T[LOGQ]==0, else S[LOGQ-1:0]; result is always < q.
REQ-011 Frame accumulation latency: one cycle per beat; the sum of beat k is visible in acc on the cycle after beat k transfers.
REQ-012 out_valid SHALL assert on the cycle after the in_last beat transfers; out_data = acc, out_count = count.
REQ-013 DONE: out_data and out_count SHALL hold steady while out_ready is 0; when the result transfers, next state is IDLE.
REQ-014 A beat offered in DONE is not accepted, even in the cycle the result transfers; the earliest next beat is accepted in the cycle after the result transfers.
REQ-015 No beat transfers in a cycle: acc, count and state hold.
REQ-016 qH changes during a frame SHALL NOT affect that frame; q_reg is updated only by the first beat of a frame.
REQ-017 Single-beat frame (in_last on the first beat): out_data = in_data, out_count = 1.
REQ-018 Result is undefined if any in_data >= q; no checking is required.

Reset
REQ-019 rst==1 at a clock edge SHALL force state IDLE, acc=0, count=0, q_reg=0, out_valid=0, in_ready=1 on the following cycle, regardless of any handshake in that cycle.
REQ-020 Reset during ACC or DONE SHALL discard the partial or pending frame; no result for it is ever emitted.
REQ-021 out_data and out_count SHALL read 0 after reset until the first result.

Verification (qH=47'h400008C00000, LOGQ=64, giving q=64'h8000118000000001)
REQ-022 Frame {5, 7, 9(last)}, out_ready=1 -> out_valid on the cycle after beat 3; out_data=21, out_count=3.
REQ-023 Frame {q-1, 2(last)} -> out_data=1; frame {q-1, q-1(last)} -> out_data=64'h8000117FFFFFFFFF.
REQ-024 Single beat 64'h010000000000000A with in_last, out_ready held 0 for 5 cycles -> out_valid stays 1 and out_data stays 64'h010000000000000A, in_ready stays 0; out_ready=1 -> IDLE the next cycle.
REQ-025 Back-to-back frames with in_valid held 1 -> exactly one idle (in_ready=0) cycle between frames; the second frame is summed from 0.
REQ-026 qH driven to 0 on beat 2 of frame {q-1, 2(last)} -> out_data=1, since the latched q is used.
REQ-027 rst pulsed after 2 beats of a 4-beat frame -> no out_valid; the next frame {3(last)} gives out_data=3, out_count=1.
